// File: rtl/fetch_queue.sv
// fetch_queue: LANES-wide circular instruction queue between fetch and decode.
// Validity derives only from count, so the storage array carries no reset.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flash,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0][31:0]  in_pc,
    input  logic [LANES-1:0][31:0]  in_inst,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES-1:0][31:0]  out_pc,
    output logic [LANES-1:0][31:0]  out_inst,
    input  logic [2:0]              pop_number,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] push_n, pop_req, pop_n;
    logic          run, do_push;
    // push_n counts the unbroken run of valid lanes starting at lane 0
    always_comb begin
        push_n = '0;
        run = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            run = run & in_valid[i];
            push_n = push_n + CW'(run);
        end
        pop_req = CW'(pop_number) > CW'(LANES) ? CW'(LANES) : CW'(pop_number);
        pop_n = pop_req > count ? count : pop_req;
    end
    assign in_ready = CW'(DEPTH) - count >= CW'(LANES);
    assign do_push = in_ready & ~flash;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pop_n[AW-1:0];
            tail  <= tail + (do_push ? push_n[AW-1:0] : '0);
            count <= count + (do_push ? push_n : '0) - pop_n;
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (do_push && CW'(i) < push_n) begin
                pc_mem[tail + AW'(i)]   <= in_pc[i];
                inst_mem[tail + AW'(i)] <= in_inst[i];
            end
        end
    end
    always_comb begin
        out_valid = '0;
        out_pc = '0;
        out_inst = '0;
        for (int i = 0; i < LANES; i++) begin
            out_valid[i] = count > CW'(i);
            out_pc[i]    = out_valid[i] ? pc_mem[head + AW'(i)]   : '0;
            out_inst[i]  = out_valid[i] ? inst_mem[head + AW'(i)] : '0;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors for fetch_queue, checked each cycle against a queue model.
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam int LANES = 4;
    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flash = 1'b0;
    logic [LANES-1:0]       in_valid = '0;
    logic [LANES-1:0][31:0] in_pc = '0;
    logic [LANES-1:0][31:0] in_inst = '0;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES-1:0][31:0] out_pc;
    logic [LANES-1:0][31:0] out_inst;
    logic [2:0]             pop_number = '0;
    logic [3:0]             count;
    int checks = 0;
    int errors = 0;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t q[$];
    int pn;
    bit rdy;

    fetch_queue #(.DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .flash(flash), .in_valid(in_valid),
        .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .pop_number(pop_number), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: FIFO of entries; pops come off the front, accepted lanes go on the back
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flash) q.delete();
        else begin
            rdy = (DEPTH - q.size()) >= LANES;
            pn = (pop_number > LANES) ? LANES : int'(pop_number);
            if (pn > q.size()) pn = q.size();
            repeat (pn) void'(q.pop_front());
            if (rdy)
                for (int i = 0; i < LANES && in_valid[i]; i++)
                    q.push_back('{in_pc[i], in_inst[i]});
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'((DEPTH - q.size()) >= LANES));
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(i < q.size()));
            chk($sformatf("out_pc[%0d]", i), out_pc[i], i < q.size() ? q[i].pc : 32'h0);
            chk($sformatf("out_inst[%0d]", i), out_inst[i], i < q.size() ? q[i].inst : 32'h0);
        end
    end

    task automatic drive(input logic [3:0] mask, input logic [31:0] base, input logic [2:0] pop, input logic fl);
        in_valid = mask;
        pop_number = pop;
        flash = fl;
        for (int i = 0; i < LANES; i++) begin
            in_pc[i] = base + 32'(4 * i);
            in_inst[i] = (base ^ 32'hCAFE0000) + 32'(i);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("rst count", 32'(count), 0);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_pc0", out_pc[0], 0);
        step;
        step;
        rst_n = 1'b1;
        // push from empty
        drive(4'b1111, 32'h100, 0, 0);
        step;
        chk("push count", 32'(count), 4);
        chk("push out_valid", 32'(out_valid), 32'hF);
        chk("push out_pc0", out_pc[0], 32'h100);
        chk("push out_pc3", out_pc[3], 32'h10C);
        chk("push in_ready", 32'(in_ready), 1);
        // fill, then an ignored push
        drive(4'b1111, 32'h200, 0, 0);
        step;
        chk("full count", 32'(count), 8);
        chk("full in_ready", 32'(in_ready), 0);
        drive(4'b1111, 32'h300, 0, 0);
        step;
        chk("full hold count", 32'(count), 8);
        chk("full hold pc0", out_pc[0], 32'h100);
        // move head to slot 6 with six entries (slots 6,7,0..3)
        drive(4'b0000, 32'h0, 4, 0);
        step;
        drive(4'b0000, 32'h0, 2, 0);
        step;
        drive(4'b1111, 32'h400, 0, 0);
        step;
        chk("wrap pre count", 32'(count), 6);
        chk("wrap pre pc0", out_pc[0], 32'h208);
        chk("wrap pre in_ready", 32'(in_ready), 0);
        // pop 3 with a push that is refused because in_ready is low; head wraps to slot 1
        drive(4'b1111, 32'h600, 3, 0);
        step;
        chk("wrap count", 32'(count), 3);
        chk("wrap pc0", out_pc[0], 32'h404);
        chk("wrap pc2", out_pc[2], 32'h40C);
        // drain, then non-contiguous mask
        drive(4'b0000, 32'h0, 3, 0);
        step;
        chk("drain count", 32'(count), 0);
        drive(4'b1011, 32'h500, 0, 0);
        step;
        chk("mask count", 32'(count), 2);
        chk("mask out_valid", 32'(out_valid), 32'h3);
        chk("mask pc1", out_pc[1], 32'h504);
        chk("mask pc2", out_pc[2], 0);
        // reach five entries, then flash with a push and pop pending
        drive(4'b0111, 32'h700, 0, 0);
        step;
        chk("pre flash count", 32'(count), 5);
        drive(4'b1111, 32'h800, 2, 1);
        step;
        chk("flash count", 32'(count), 0);
        chk("flash out_valid", 32'(out_valid), 0);
        chk("flash in_ready", 32'(in_ready), 1);
        // over-pop
        drive(4'b0011, 32'h900, 0, 0);
        step;
        chk("overpop pre", 32'(count), 2);
        drive(4'b0000, 32'h0, 4, 0);
        step;
        chk("overpop count", 32'(count), 0);
        // pop_number above LANES clamps
        drive(4'b1111, 32'hA00, 0, 0);
        step;
        drive(4'b0111, 32'hB00, 7, 0);
        step;
        chk("clamp count", 32'(count), 3);
        chk("clamp pc0", out_pc[0], 32'hB00);
        drive(4'b0000, 32'h0, 0, 0);
        step;
        chk("idle count", 32'(count), 3);
        chk("idle inst1", out_inst[1], 32'hCAFE0B01);
        // asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("async count", 32'(count), 0);
        chk("async out_valid", 32'(out_valid), 0);
        chk("async in_ready", 32'(in_ready), 1);
        step;
        rst_n = 1'b1;
        drive(4'b1111, 32'hC00, 0, 0);
        step;
        drive(4'b1111, 32'hD00, 1, 0);
        step;
        chk("resume count", 32'(count), 7);
        chk("resume pc0", out_pc[0], 32'hC04);
        drive(4'b0000, 32'h0, 4, 0);
        step;
        step;
        drive(4'b0000, 32'h0, 0, 0);
        step;
        chk("end count", 32'(count), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
